// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the multiply issue/stall/writeback controller.
package mul_ctrl_pkg;

    localparam int XLEN = 32;

    // Controller sequencing: capture, start pulse, wait for product, retire.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // RV32M multiply encodings in funct3; 1xx belongs to the divide group.
    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011
    } mfunct_t;

    // Only the multiply half of the M group is handled by this controller.
    function automatic logic f3_is_mul(input logic [2:0] f3);
        return ~f3[2];
    endfunction

endpackage

// File: rtl/mulh_fixup.sv
// Turns the signed 64-bit product into the word each MUL* variant retires.
// The multiplier always treats both operands as signed; the unsigned
// interpretations differ only in the high word, by adding the other operand
// whenever an operand's top bit would have carried 2^32 of extra weight.
module mulh_fixup
    import mul_ctrl_pkg::*;
(
    input  logic [2*XLEN-1:0] ab,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [2:0]        funct3,
    output logic [XLEN-1:0]   result
);

    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] corr_a;
    logic [XLEN-1:0] corr_b;

    assign hi = ab[2*XLEN-1:XLEN];
    assign lo = ab[XLEN-1:0];

    // b treated as unsigned adds a*2^32 when b is negative as a signed value.
    assign corr_a = b[XLEN-1] ? a : '0;
    // a treated as unsigned adds b*2^32 when a is negative as a signed value.
    assign corr_b = a[XLEN-1] ? b : '0;

    // Select the retired word; wraps modulo 2^32 like the architectural result.
    always_comb begin
        result = '0;
        case (funct3)
            F3_MUL:    result = lo;
            F3_MULH:   result = hi;
            F3_MULHSU: result = hi + corr_a;
            F3_MULHU:  result = hi + corr_a + corr_b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Sits between the single-cycle decode stage and a multicycle shift-add
// multiplier. Captures operands on request, fires one start pulse, stalls the
// CPU while the multiplier runs, then writes back the selected word. A
// watchdog forces completion with an error if the product never arrives.
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     rs1_val,
    input  logic [XLEN-1:0]     rs2_val,
    input  logic [4:0]          rd,
    output logic                stall,
    output logic                wb_en,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                err,
    output logic                mul_start,
    output logic [XLEN-1:0]     mul_a,
    output logic [XLEN-1:0]     mul_b,
    input  logic [2*XLEN-1:0]   mul_ab,
    input  logic                mul_done
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t          state_reg;
    state_t          state_next;

    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [4:0]      rd_reg;
    logic [2:0]      f3_reg;
    logic            err_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0] result_reg;

    logic [XLEN-1:0] fix_result;
    logic            cnt_expired;

    assign cnt_expired = (cnt_reg == CNT_LAST);

    // Product-to-result conversion uses the captured operands and opcode so a
    // CPU that changes its operand buses mid-stall cannot corrupt the result.
    mulh_fixup u_fixup (
        .ab     (mul_ab),
        .a      (a_reg),
        .b      (b_reg),
        .funct3 (f3_reg),
        .result (fix_result)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and control outputs; stall in IDLE reacts to req in the same
    // cycle so the CPU never advances past a multiply it has just decoded.
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        mul_start  = 1'b0;
        wb_en      = 1'b0;
        err        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    stall      = 1'b1;
                    state_next = f3_is_mul(funct3) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                stall      = 1'b1;
                mul_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (mul_done || cnt_expired) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                wb_en      = (rd_reg != 5'd0) && !err_reg;
                err        = err_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, watchdog and result register. The product is only
    // looked at while waiting, so a stray done indication elsewhere is inert.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            rd_reg     <= '0;
            f3_reg     <= '0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        a_reg      <= rs1_val;
                        b_reg      <= rs2_val;
                        rd_reg     <= rd;
                        f3_reg     <= funct3;
                        err_reg    <= ~f3_is_mul(funct3);
                        result_reg <= '0;
                    end
                end
                ISSUE: begin
                    cnt_reg <= '0;
                end
                WAIT: begin
                    if (mul_done) begin
                        result_reg <= fix_result;
                    end else if (cnt_expired) begin
                        result_reg <= '0;
                        err_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mul_a   = a_reg;
    assign mul_b   = b_reg;
    assign wb_rd   = rd_reg;
    assign wb_data = result_reg;

endmodule
